// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync request controller: request struct and stats width.
package fractal_sync_pkg;

  localparam int unsigned SYNC_IDX_WIDTH = 8;
  localparam int unsigned STATS_W        = 32;

  typedef struct packed {
    logic                      valid;
    logic [SYNC_IDX_WIDTH-1:0] id;
  } sync_req_t;

endpackage

// File: rtl/fractal_sync_req_stage.sv
// One-entry valid/ready buffer; refills in the same cycle the held entry is consumed.
module fractal_sync_req_stage #(
  parameter int unsigned ID_W = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [ID_W-1:0] id_i,
  input  logic            consume_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;

  assign ready_o = !valid_q || consume_i;
  assign valid_o = valid_q;
  assign id_o    = id_q;

  // Next entry: load on free slot, otherwise hold; id is kept when nothing new arrives.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    if (ready_o) begin
      valid_d = valid_i;
      id_d    = valid_i ? id_i : id_q;
    end else begin
      valid_d = valid_q;
      id_d    = id_q;
    end
  end

  // Entry register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: rtl/fractal_sync_req_ctrl.sv
// Barrier-arrival request controller in front of the fractal sync RF.
// Optional completion counter: FRACTAL_SYNC_REQ_CTRL_STATS_EN.
module fractal_sync_req_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_REGS    = 2,
  parameter int unsigned IDX_WIDTH = 1,
  parameter int unsigned N_PORTS   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_PORTS-1:0]                req_valid_i,
  input  logic [N_PORTS-1:0][IDX_WIDTH-1:0] req_id_i,
  output logic [N_PORTS-1:0]                req_ready_o,
  output logic [N_PORTS-1:0]                rf_data_o,
  output logic [N_PORTS-1:0][IDX_WIDTH-1:0] rf_idx_o,
  output logic [N_PORTS-1:0]                rf_idx_valid_o,
  input  logic [N_PORTS-1:0]                rf_data_i,
  output logic [N_PORTS-1:0]                done_valid_o,
  output logic [N_PORTS-1:0][IDX_WIDTH-1:0] done_id_o,
  input  logic [N_PORTS-1:0]                done_ready_i,
  output logic [N_PORTS-1:0]                err_o,
  output logic [STATS_W-1:0]                n_sync_o
);

  if ((2 ** IDX_WIDTH) < N_REGS || IDX_WIDTH > SYNC_IDX_WIDTH) begin : g_idx_chk
    $error("fractal_sync_req_ctrl: IDX_WIDTH does not fit N_REGS");
  end

  logic [N_PORTS-1:0]              s_valid_s, s_consume_s, d_load_s, d_ready_s;
  logic [N_PORTS-1:0]              in_rng_s, need_s, blocked_s, hold_s;
  logic [N_PORTS-1:0][N_PORTS-1:0] match_s;
  sync_req_t [N_PORTS-1:0]         stage_s;
  int                              rank_s [N_PORTS];
  int                              arr_s  [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    fractal_sync_req_stage #(.ID_W(IDX_WIDTH)) u_req (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (req_valid_i[p]),
      .id_i      (req_id_i[p]),
      .consume_i (s_consume_s[p]),
      .ready_o   (req_ready_o[p]),
      .valid_o   (s_valid_s[p]),
      .id_o      (rf_idx_o[p])
    );

    fractal_sync_req_stage #(.ID_W(IDX_WIDTH)) u_done (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (d_load_s[p]),
      .id_i      (rf_idx_o[p]),
      .consume_i (done_ready_i[p]),
      .ready_o   (d_ready_s[p]),
      .valid_o   (done_valid_o[p]),
      .id_o      (done_id_o[p])
    );
  end

  // Conflict groups: the lowest port (rank 0) owns the RF access; arrivals = group size + old flag,
  // completions go to the lowest-ranked members; any blocked member stalls its whole group.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      stage_s[p].valid = s_valid_s[p];
      stage_s[p].id    = SYNC_IDX_WIDTH'(rf_idx_o[p]);
      in_rng_s[p]      = s_valid_s[p] && (stage_s[p].id < SYNC_IDX_WIDTH'(N_REGS));
    end
    for (int p = 0; p < N_PORTS; p++) begin
      rank_s[p] = 0;
      arr_s[p]  = 0;
      for (int q = 0; q < N_PORTS; q++) begin
        match_s[p][q] = in_rng_s[p] && in_rng_s[q] && (stage_s[q].id == stage_s[p].id);
        arr_s[p]      = arr_s[p] + int'(match_s[p][q]);
        rank_s[p]     = rank_s[p] + int'(match_s[p][q] && (q < p));
        arr_s[p]      = arr_s[p] + int'(match_s[p][q] && (q < p) && (rank_s[p] == 1) && rf_data_i[q]);
      end
      arr_s[p]     = arr_s[p] + int'(in_rng_s[p] && (rank_s[p] == 0) && rf_data_i[p]);
      need_s[p]    = in_rng_s[p] && (rank_s[p] < (arr_s[p] / 2));
      blocked_s[p] = need_s[p] && !d_ready_s[p];
    end
    for (int p = 0; p < N_PORTS; p++) begin
      hold_s[p]         = |(match_s[p] & blocked_s);
      s_consume_s[p]    = s_valid_s[p] && !hold_s[p];
      err_o[p]          = s_valid_s[p] && !in_rng_s[p];
      d_load_s[p]       = need_s[p] && !hold_s[p];
      rf_idx_valid_o[p] = in_rng_s[p] && (rank_s[p] == 0) && !hold_s[p];
      rf_data_o[p]      = rf_idx_valid_o[p] && ((arr_s[p] % 2) == 1);
    end
  end

`ifdef FRACTAL_SYNC_REQ_CTRL_STATS_EN
  localparam int unsigned SUM_W = STATS_W + 1;

  logic [STATS_W-1:0] n_sync_q, n_sync_d;
  logic [SUM_W-1:0]   sum_s;

  // Saturating sum of this cycle's completion loads.
  always_comb begin
    sum_s = {1'b0, n_sync_q};
    for (int p = 0; p < N_PORTS; p++) begin
      sum_s = sum_s + SUM_W'(d_load_s[p]);
    end
    if (sum_s[STATS_W]) begin
      n_sync_d = {STATS_W{1'b1}};
    end else begin
      n_sync_d = sum_s[STATS_W-1:0];
    end
  end

  // Completion counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_sync_q <= {STATS_W{1'b0}};
    end else begin
      n_sync_q <= n_sync_d;
    end
  end

  assign n_sync_o = n_sync_q;
`else
  assign n_sync_o = {STATS_W{1'b0}};
`endif

endmodule
